// File: rtl/axi_pkg.sv
// Shared AXI write-master encodings, FSM state type and command legality check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_8B     = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } wr_state_e;

    // A command is illegal if it uses the reserved burst type, is a WRAP with a
    // non power-of-two beat count or unaligned start, or is an INCR that would
    // run past the 4 KiB page. Only the page offset of the address matters.
    function automatic logic cmd_illegal(input logic [11:0] addr_lo,
                                         input logic [7:0]  len,
                                         input logic [1:0]  burst);
        logic [12:0] end_off;
        logic        bad;
        end_off = {1'b0, addr_lo} + (({5'd0, len} + 13'd1) << 3);
        bad     = 1'b0;
        case (burst)
            BURST_RSVD: bad = 1'b1;
            BURST_WRAP: bad = !((len == 8'd1) || (len == 8'd3) ||
                                (len == 8'd7) || (len == 8'd15)) ||
                              (addr_lo[2:0] != 3'b000);
            BURST_INCR: bad = (end_off > 13'd4096);
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/axi_wr_burst_master.sv
// AXI write burst master: turns a command plus a beat stream into AW/W, tracks B.
// Latency: awvalid one cycle after command accept; W beats pass combinationally.
// Backpressure: cmd_ready drops outside IDLE or when MAXOUT bursts await B; W follows wready.
module axi_wr_burst_master
    import axi_pkg::*;
#(
    parameter int AW     = 32,
    parameter int MAXOUT = 4
) (
    input  logic          axi_aclk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [7:0]    cmd_len,
    input  logic [1:0]    cmd_burst,
    input  logic          data_valid,
    output logic          data_ready,
    input  logic [63:0]   data_wdata,
    input  logic [7:0]    data_wstrb,
    output logic [AW-1:0] axi_awaddr,
    output logic [7:0]    axi_awlen,
    output logic [2:0]    axi_awsize,
    output logic [1:0]    axi_awburst,
    output logic          axi_awvalid,
    input  logic          axi_awready,
    output logic [63:0]   axi_wdata,
    output logic [7:0]    axi_wstrb,
    output logic          axi_wlast,
    output logic          axi_wvalid,
    input  logic          axi_wready,
    input  logic [1:0]    axi_bresp,
    input  logic          axi_bvalid,
    output logic          axi_bready,
    output logic          done,
    output logic          err
);

    localparam int             OW       = $clog2(MAXOUT + 1);
    localparam logic [OW-1:0]  MAXOUT_C = OW'(MAXOUT);

    wr_state_e     state_q,   state_d;
    logic [AW-1:0] awaddr_q,  awaddr_d;
    logic [7:0]    awlen_q,   awlen_d;
    logic [1:0]    awburst_q, awburst_d;
    logic          awvalid_q, awvalid_d;
    logic [7:0]    beat_q,    beat_d;
    logic [OW-1:0] outs_q,    outs_d;
    logic          done_q,    done_d;
    logic          err_q,     err_d;

    logic in_data;
    logic cmd_fire;
    logic cmd_bad;
    logic w_fire;
    logic w_last;
    logic b_fire;

    // Handshake qualifiers shared by the next-state logic and the outputs.
    always_comb begin
        in_data   = (state_q == ST_DATA);
        cmd_ready = (state_q == ST_IDLE) && (outs_q < MAXOUT_C);
        cmd_fire  = cmd_valid && cmd_ready;
        cmd_bad   = cmd_illegal(cmd_addr[11:0], cmd_len, cmd_burst);
        w_last    = in_data && (beat_q == awlen_q);
        w_fire    = in_data && data_valid && axi_wready;
        b_fire    = axi_bvalid && (outs_q != '0);
    end

    // Burst FSM: accept/validate command, present AW, stream W beats.
    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awburst_d = awburst_q;
        awvalid_d = awvalid_q;
        beat_d    = beat_q;
        done_d    = b_fire;
        err_d     = err_q || (b_fire && (axi_bresp != RESP_OKAY));
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        // Rejected commands never reach the bus.
                        err_d = 1'b1;
                    end else begin
                        awaddr_d  = cmd_addr;
                        awlen_d   = cmd_len;
                        awburst_d = cmd_burst;
                        awvalid_d = 1'b1;
                        state_d   = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (axi_awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = 8'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fire) begin
                    if (w_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outstanding-burst count: up on last W beat, down on B; both at once cancel.
    always_comb begin
        outs_d = outs_q;
        case ({w_fire && w_last, b_fire})
            2'b10:   outs_d = outs_q + OW'(1);
            2'b01:   outs_d = outs_q - OW'(1);
            default: outs_d = outs_q;
        endcase
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awburst_q <= '0;
            awvalid_q <= 1'b0;
            beat_q    <= '0;
            outs_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awburst_q <= awburst_d;
            awvalid_q <= awvalid_d;
            beat_q    <= beat_d;
            outs_q    <= outs_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Output drive: AW is registered, W is a gated pass-through of the beat stream.
    always_comb begin
        axi_awaddr  = awaddr_q;
        axi_awlen   = awlen_q;
        axi_awsize  = SIZE_8B;
        axi_awburst = awburst_q;
        axi_awvalid = awvalid_q;
        axi_wdata   = data_wdata;
        axi_wstrb   = data_wstrb;
        axi_wvalid  = in_data && data_valid;
        data_ready  = in_data && axi_wready;
        axi_wlast   = w_last;
        axi_bready  = (outs_q != '0);
        done        = done_q;
        err         = err_q;
    end

endmodule

// File: doc/axi_wr_burst_master.md
AXI_WR_BURST_MASTER -- requirements
Module: axi_wr_burst_master

Interface
REQ-001 SHALL have parameter AW, 32, address width.
REQ-002 SHALL have parameter MAXOUT, 4, max bursts with last W beat sent and B not yet received.
REQ-003 SHALL have port axi_aclk  in  1  single clock; all logic is posedge-triggered.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid  in  1  burst command valid.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_addr  in  AW  burst start byte address.
REQ-008 SHALL have port cmd_len  in  8  beats minus one.
REQ-009 SHALL have port cmd_burst  in  2  FIXED/INCR/WRAP/reserved.
REQ-010 SHALL have port data_valid  in  1  write-data beat valid.
REQ-011 SHALL have port data_ready  out  1  write-data beat consumed.
REQ-012 SHALL have port data_wdata  in  64  beat data.
REQ-013 SHALL have port data_wstrb  in  8  beat byte strobes.
REQ-014 SHALL have port axi_awaddr  out  AW  AW address.
REQ-015 SHALL have port axi_awlen  out  8  AW length.
REQ-016 SHALL have port axi_awsize  out  3  AW size, constant 3'b011 (8 bytes).
REQ-017 SHALL have port axi_awburst  out  2  AW burst type.
REQ-018 SHALL have port axi_awvalid  out  1  AW valid, registered.
REQ-019 SHALL have port axi_awready  in  1  AW ready from the AXI handshake FSM.
REQ-020 SHALL have port axi_wdata  out  64  W data.
REQ-021 SHALL have port axi_wstrb  out  8  W strobes.
REQ-022 SHALL have port axi_wlast  out  1  W last beat.
REQ-023 SHALL have port axi_wvalid  out  1  W valid.
REQ-024 SHALL have port axi_wready  in  1  W ready.
REQ-025 SHALL have port axi_bresp  in  2  write response.
REQ-026 SHALL have port axi_bvalid  in  1  response valid.
REQ-027 SHALL have port axi_bready  out  1  response ready.
REQ-028 SHALL have port done  out  1  one-cycle pulse per B handshake.
REQ-029 SHALL have port err  out  1  sticky: nonzero bresp or rejected command.

Function
REQ-030 SHALL implement states IDLE, ADDR, DATA.
REQ-031 IDLE: cmd_ready = (outstanding < MAXOUT); on cmd_valid&&cmd_ready latch addr/len/burst.
- Legal command -> ADDR with axi_awvalid=1 next cycle.
- Illegal command -> err set, stay IDLE, no AXI traffic.
REQ-032 Illegal SHALL mean: burst==2'b11; WRAP with len not in {1,3,7,15} or addr not 8-byte aligned; INCR where addr[11:0] + (len+1)*8, computed at 13 bits, exceeds 4096.
REQ-033 ADDR: AW outputs SHALL hold stable while axi_awvalid=1; on axi_awready -> awvalid=0, beat counter=0, DATA.
REQ-034 DATA: axi_wvalid=data_valid, data_ready=axi_wready, data passes combinationally; all three forced 0 outside DATA.
REQ-035 axi_wlast SHALL be (beat counter == latched len) in DATA; counter increments per W handshake (8-bit, no wrap: len ≤ 255).
REQ-036 W handshake with wlast SHALL return to IDLE and increment outstanding.
REQ-037 axi_bready SHALL be 1 whenever outstanding > 0; B handshake decrements outstanding and pulses done next cycle.
REQ-038 Simultaneous last-W and B handshakes SHALL leave outstanding unchanged.
REQ-039 B handshake with bresp != 2'b00 SHALL set err; err clears only on rst.
REQ-040 Back-to-back commands SHALL incur exactly one IDLE cycle between last W beat and next awvalid.

Reset
REQ-041 On rst: state IDLE, axi_awvalid=0, beat counter=0, outstanding=0, done=0, err=0, AW fields 0.
REQ-042 Reset mid-burst SHALL abandon the burst immediately; no wlast or B is owed.

Structure
REQ-043 Package axi_pkg SHALL hold burst encodings (FIXED 00, INCR 01, WRAP 10), resp encodings (OKAY 00, SLVERR 10), and the state enum.
REQ-044 SHALL be one module with no sub-modules.

Verification
REQ-045 INCR addr 0x100, len 3, awready/wready always 1 -> AW at cycle 1, 4 W beats, wlast on beat 3, OKAY -> done pulse, err=0.
REQ-046 INCR addr 0xFF8, len 1 -> err=1, no awvalid, cmd_ready stays 1.
REQ-047 WRAP len 2 -> rejected, err=1; WRAP addr 0x40, len 7 -> accepted, 8 beats.
REQ-048 MAXOUT=4, bvalid held 0, five len-0 commands -> fifth stalls with cmd_ready=0 until one B handshake.
REQ-049 wready toggling 1/0 during len 7 -> data_ready mirrors wready, exactly 8 beats, wlast only on 8th; bresp=SLVERR -> err=1.
REQ-050 rst asserted during DATA beat 2 -> all outputs at reset values same cycle; new command completes normally.
